// File: rtl/drs_trigger_receiver.sv
// Readout-side receiver for the DRS master trigger line: synchronise, qualify,
// handshake with the readout sequencer, enforce dead time, count and time triggers.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready; a qualified trigger with enable set is accepted
// REQ       | trig_req_o held high until the sequencer acknowledges
// WAIT_DONE | waiting for the sequencer's readout_done_i pulse
// DEAD      | dead-time down-counter running, triggers are counted as lost
module drs_trigger_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 1,
   parameter int DEAD_TIME   = 100
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        dtrig_i,
   input  logic [31:0] status_reg,
   output logic        trig_req_o,
   input  logic        trig_ack_i,
   input  logic        readout_done_i,
   output logic        busy_o,
   output logic [31:0] trig_cnt_o,
   output logic [15:0] lost_cnt_o,
   output logic [31:0] period_o,
   output logic        period_valid_o
);

   localparam int HW = $clog2(MIN_WIDTH + 1);
   localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DONE = 2'd2,
      DEAD      = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [HW-1:0]          hlen_q, hlen_d;
   logic                   qtrig_q, qtrig_d;
   logic                   req_q, req_d;
   logic                   busy_q, busy_d;
   logic [DW-1:0]          dead_q, dead_d;
   logic [31:0]            trig_cnt_q, trig_cnt_d;
   logic [15:0]            lost_cnt_q, lost_cnt_d;
   logic [31:0]            per_cnt_q, per_cnt_d;
   logic [31:0]            period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   first_q, first_d;

   logic                   sync_hi;
   logic                   enable;
   logic                   clear;
   logic                   accept;
   logic                   lost;
   logic [29:0]            status_unused;

   assign sync_hi       = sync_q[SYNC_STAGES-1];
   assign enable        = status_reg[0];
   assign clear         = status_reg[1];
   assign status_unused = status_reg[31:2];

   // qtrig is registered so it is high exactly in the cycle hlen_q reaches MIN_WIDTH
   always_comb begin
      hlen_d  = '0;
      qtrig_d = 1'b0;
      if (sync_hi) begin
         if (hlen_q == HW'(MIN_WIDTH)) begin
            hlen_d = hlen_q;
         end else begin
            hlen_d = hlen_q + HW'(1);
         end
         qtrig_d = (hlen_q == HW'(MIN_WIDTH - 1));
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      dead_d  = dead_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (qtrig_q && enable) begin
               state_d = REQ;
               req_d   = 1'b1;
               accept  = 1'b1;
            end
         end
         REQ: begin
            if (trig_ack_i) begin
               state_d = WAIT_DONE;
               req_d   = 1'b0;
            end
         end
         WAIT_DONE: begin
            if (readout_done_i) begin
               state_d = DEAD;
               dead_d  = DW'(DEAD_TIME - 1);
            end
         end
         DEAD: begin
            if (dead_q == '0) begin
               state_d = IDLE;
            end else begin
               dead_d = dead_q - DW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
      lost   = qtrig_q && !accept;
      busy_d = (state_d != IDLE);
   end

   // clear wins over any increment landing in the same cycle
   always_comb begin
      trig_cnt_d = trig_cnt_q;
      lost_cnt_d = lost_cnt_q;
      period_d   = period_q;
      first_d    = first_q;
      valid_d    = 1'b0;
      per_cnt_d  = per_cnt_q;

      if (accept) begin
         per_cnt_d = 32'd1;
      end else if (per_cnt_q != 32'hFFFF_FFFF) begin
         per_cnt_d = per_cnt_q + 32'd1;
      end

      if (clear) begin
         trig_cnt_d = '0;
         lost_cnt_d = '0;
         period_d   = '0;
         first_d    = 1'b0;
      end else begin
         if (accept) begin
            trig_cnt_d = trig_cnt_q + 32'd1;
            first_d    = 1'b1;
            if (first_q) begin
               period_d = per_cnt_q;
               valid_d  = 1'b1;
            end
         end
         if (lost && (lost_cnt_q != 16'hFFFF)) begin
            lost_cnt_d = lost_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         hlen_q     <= '0;
         qtrig_q    <= 1'b0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         dead_q     <= '0;
         trig_cnt_q <= '0;
         lost_cnt_q <= '0;
         per_cnt_q  <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], dtrig_i};
         hlen_q     <= hlen_d;
         qtrig_q    <= qtrig_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         dead_q     <= dead_d;
         trig_cnt_q <= trig_cnt_d;
         lost_cnt_q <= lost_cnt_d;
         per_cnt_q  <= per_cnt_d;
         period_q   <= period_d;
         valid_q    <= valid_d;
         first_q    <= first_d;
      end
   end

   assign trig_req_o     = req_q;
   assign busy_o         = busy_q;
   assign trig_cnt_o     = trig_cnt_q;
   assign lost_cnt_o     = lost_cnt_q;
   assign period_o       = period_q;
   assign period_valid_o = valid_q;

endmodule

// File: tb/tb_drs_trigger_receiver.sv
// Directed bench for drs_trigger_receiver: one default instance and one with
// MIN_WIDTH=4 / DEAD_TIME=8 for the pulse-width qualification cases.
module tb_drs_trigger_receiver;

   localparam int P = 500;

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic [31:0] status = 32'd0;

   logic        dtrig = 1'b0, ack = 1'b0, done = 1'b0;
   logic        req, busy, pvalid;
   logic [31:0] tcnt, period;
   logic [15:0] lcnt;

   logic        dtrig_w = 1'b0, ack_w = 1'b0, done_w = 1'b0;
   logic        req_w, busy_w, pvalid_w;
   logic [31:0] tcnt_w, period_w;
   logic [15:0] lcnt_w;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   drs_trigger_receiver u_dut (
      .clk(clk), .arst(arst), .dtrig_i(dtrig), .status_reg(status),
      .trig_req_o(req), .trig_ack_i(ack), .readout_done_i(done), .busy_o(busy),
      .trig_cnt_o(tcnt), .lost_cnt_o(lcnt), .period_o(period), .period_valid_o(pvalid)
   );

   drs_trigger_receiver #(.SYNC_STAGES(2), .MIN_WIDTH(4), .DEAD_TIME(8)) u_dut_w4 (
      .clk(clk), .arst(arst), .dtrig_i(dtrig_w), .status_reg(status),
      .trig_req_o(req_w), .trig_ack_i(ack_w), .readout_done_i(done_w), .busy_o(busy_w),
      .trig_cnt_o(tcnt_w), .lost_cnt_o(lcnt_w), .period_o(period_w), .period_valid_o(pvalid_w)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // one-cycle trigger on the default instance, then wait until trig_req_o would rise
   task automatic trig_and_wait();
      dtrig = 1'b1;
      tick(1);
      dtrig = 1'b0;
      tick(3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      tick(2);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tcnt", tcnt, 32'd0);
      chk("rst_lcnt", 32'(lcnt), 32'd0);
      chk("rst_period", period, 32'd0);
      chk("rst_pvalid", 32'(pvalid), 32'd0);
      arst = 1'b1;
      tick(2);

      // 1: single 3-cycle pulse, exact latency, handshake, dead time
      status = 32'd1;
      dtrig = 1'b1;
      tick(3);
      chk("t1_req_early", 32'(req), 32'd0);
      dtrig = 1'b0;
      tick(1);
      chk("t1_req_rise", 32'(req), 32'd1);
      chk("t1_tcnt", tcnt, 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_pvalid_first", 32'(pvalid), 32'd0);
      tick(4);
      chk("t1_req_held", 32'(req), 32'd1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("t1_req_fall", 32'(req), 32'd0);
      chk("t1_busy_wait", 32'(busy), 32'd1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(99);
      chk("t1_dead_last", 32'(busy), 32'd1);
      tick(1);
      chk("t1_idle", 32'(busy), 32'd0);

      // 2: periodic triggers P cycles apart
      status = 32'd3;
      tick(1);
      status = 32'd1;
      for (int i = 0; i < 10; i++) begin
         trig_and_wait();
         chk("t2_req", 32'(req), 32'd1);
         if (i == 0) begin
            chk("t2_pvalid_first", 32'(pvalid), 32'd0);
         end else begin
            chk("t2_pvalid", 32'(pvalid), 32'd1);
            chk("t2_period", period, 32'(P));
         end
         ack = 1'b1;
         tick(1);
         ack = 1'b0;
         chk("t2_pvalid_drop", 32'(pvalid), 32'd0);
         done = 1'b1;
         tick(1);
         done = 1'b0;
         tick(P - 6);
      end
      chk("t2_tcnt", tcnt, 32'd10);
      chk("t2_lcnt", 32'(lcnt), 32'd0);
      chk("t2_busy", 32'(busy), 32'd0);

      // 3: triggers during WAIT_DONE, DEAD and on the DEAD-to-IDLE cycle
      status = 32'd3;
      tick(1);
      status = 32'd1;
      chk("t3_clr_tcnt", tcnt, 32'd0);
      chk("t3_clr_period", period, 32'd0);
      trig_and_wait();
      chk("t3_req", 32'(req), 32'd1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      trig_and_wait();
      chk("t3_lost_wait", 32'(lcnt), 32'd1);
      chk("t3_noreq_wait", 32'(req), 32'd0);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      trig_and_wait();
      chk("t3_lost_dead", 32'(lcnt), 32'd2);
      chk("t3_tcnt", tcnt, 32'd1);
      tick(92);
      trig_and_wait();
      chk("t3_lost_edge", 32'(lcnt), 32'd3);
      chk("t3_busy_edge", 32'(busy), 32'd0);
      tick(3);
      chk("t3_noreq_edge", 32'(req), 32'd0);
      chk("t3_tcnt_final", tcnt, 32'd1);

      // 4: MIN_WIDTH = 4 qualification
      dtrig_w = 1'b1;
      tick(2);
      dtrig_w = 1'b0;
      tick(10);
      chk("t4_short_req", 32'(req_w), 32'd0);
      chk("t4_short_tcnt", tcnt_w, 32'd0);
      chk("t4_short_lcnt", 32'(lcnt_w), 32'd0);
      dtrig_w = 1'b1;
      tick(6);
      chk("t4_6_early", 32'(req_w), 32'd0);
      dtrig_w = 1'b0;
      tick(1);
      chk("t4_6_req", 32'(req_w), 32'd1);
      chk("t4_6_tcnt", tcnt_w, 32'd1);
      ack_w = 1'b1;
      tick(1);
      ack_w = 1'b0;
      done_w = 1'b1;
      tick(1);
      done_w = 1'b0;
      tick(12);
      chk("t4_6_idle", 32'(busy_w), 32'd0);
      dtrig_w = 1'b1;
      tick(7);
      chk("t4_40_req", 32'(req_w), 32'd1);
      ack_w = 1'b1;
      tick(1);
      ack_w = 1'b0;
      done_w = 1'b1;
      tick(1);
      done_w = 1'b0;
      tick(31);
      dtrig_w = 1'b0;
      tick(12);
      chk("t4_40_tcnt", tcnt_w, 32'd2);
      chk("t4_40_lcnt", 32'(lcnt_w), 32'd0);
      chk("t4_40_idle", 32'(busy_w), 32'd0);

      // 5: disabled triggers are lost; dropping enable mid-transaction does not abort
      status = 32'd3;
      tick(1);
      status = 32'd0;
      for (int i = 0; i < 3; i++) begin
         trig_and_wait();
         chk("t5_dis_req", 32'(req), 32'd0);
         tick(2);
      end
      chk("t5_dis_lcnt", 32'(lcnt), 32'd3);
      chk("t5_dis_tcnt", tcnt, 32'd0);
      chk("t5_dis_busy", 32'(busy), 32'd0);
      status = 32'd1;
      trig_and_wait();
      chk("t5_req", 32'(req), 32'd1);
      status = 32'd0;
      tick(3);
      chk("t5_req_held", 32'(req), 32'd1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("t5_req_fall", 32'(req), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(100);
      chk("t5_idle", 32'(busy), 32'd0);
      chk("t5_tcnt", tcnt, 32'd1);

      // 6: async reset in WAIT_DONE, then clear coincident with an accepted trigger
      status = 32'd1;
      trig_and_wait();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("t6_busy_pre", 32'(busy), 32'd1);
      arst = 1'b0;
      #1;
      chk("t6_arst_busy", 32'(busy), 32'd0);
      chk("t6_arst_tcnt", tcnt, 32'd0);
      chk("t6_arst_period", period, 32'd0);
      tick(2);
      arst = 1'b1;
      tick(1);
      trig_and_wait();
      chk("t6_req", 32'(req), 32'd1);
      chk("t6_tcnt", tcnt, 32'd1);
      chk("t6_pvalid", 32'(pvalid), 32'd0);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(101);
      chk("t6_idle", 32'(busy), 32'd0);
      dtrig = 1'b1;
      tick(1);
      dtrig = 1'b0;
      tick(2);
      status = 32'd3;
      tick(1);
      status = 32'd1;
      chk("t6_clr_req", 32'(req), 32'd1);
      chk("t6_clr_tcnt", tcnt, 32'd0);
      chk("t6_clr_lcnt", 32'(lcnt), 32'd0);
      chk("t6_clr_period", period, 32'd0);
      chk("t6_clr_pvalid", 32'(pvalid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
